// File: rtl/conv_data_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// conv_data_param -- streaming KxK convolution: line buffer, window, N_OC MAC lanes
// Optional macro CONV_RELU_EN clamps negative channel sums to zero. Rev 1.0
// ============================================================================
module conv_data_param #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int K      = 3,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int N_OC   = 4,
  localparam int CH_W  = (N_OC > 1) ? $clog2(N_OC) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [DATA_W-1:0]         pixel_i,
  input  logic                      pixel_valid,
  output logic                      pixel_ready,
  input  logic                      weight_we,
  input  logic [CH_W-1:0]           weight_ch,
  input  logic [K*K*DATA_W-1:0]     weight_i,
  output logic [N_OC*ACC_W-1:0]     conv_o,
  output logic                      conv_valid,
  input  logic                      conv_ready,
  output logic                      frame_done
);

  localparam int TAPS   = K * K;
  localparam int PROD_W = 2 * DATA_W;
  localparam int SR_LEN = (K - 1) * IMG_W + K;
  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_WIN  = COL_W'(K - 1);
  localparam logic [ROW_W-1:0] ROW_WIN  = ROW_W'(K - 1);

  function automatic logic signed [PROD_W-1:0] mul_s(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [PROD_W-1:0] ae;
    logic signed [PROD_W-1:0] be;
    ae = {{DATA_W{a[DATA_W-1]}}, a};
    be = {{DATA_W{b[DATA_W-1]}}, b};
    return ae * be;
  endfunction

  logic                     adv;
  logic                     accept;
  logic [COL_W-1:0]         col_q, col_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic                     win_valid_q, win_valid_d;
  logic                     frame_done_q, frame_done_d;
  logic                     s1_valid_q;
  logic                     conv_valid_q;
  logic [N_OC*ACC_W-1:0]    conv_q, conv_d;

  logic signed [DATA_W-1:0] sr_q   [SR_LEN];
  logic signed [DATA_W-1:0] win    [TAPS];
  logic signed [DATA_W-1:0] wgt_q  [N_OC][TAPS];
  logic signed [PROD_W-1:0] prod_q [N_OC][TAPS];
  logic signed [PROD_W-1:0] prod_d [N_OC][TAPS];

  assign adv         = !conv_valid_q | conv_ready;
  assign pixel_ready = adv;
  assign accept      = pixel_valid & adv & !flush;
  assign conv_o      = conv_q;
  assign conv_valid  = conv_valid_q;
  assign frame_done  = frame_done_q;

  // Raster position tracking; the window-valid flag marks pixels that complete a full KxK window.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_valid_d  = win_valid_q;
    frame_done_d = 1'b0;
    if (flush) begin
      col_d       = '0;
      row_d       = '0;
      win_valid_d = 1'b0;
    end else if (adv) begin
      win_valid_d = 1'b0;
      if (pixel_valid) begin
        win_valid_d  = (row_q >= ROW_WIN) && (col_q >= COL_WIN);
        frame_done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
    end
  end

  // Line buffer as one shift register; the window taps are fixed offsets into it.
  always_ff @(posedge clk) begin
    if (accept) begin
      sr_q[0] <= pixel_i;
      for (int i = 1; i < SR_LEN; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win[r*K + c] = sr_q[(K-1-r)*IMG_W + (K-1-c)];
      end
    end
  end

  always_comb begin
    for (int ch = 0; ch < N_OC; ch++) begin
      for (int t = 0; t < TAPS; t++) begin
        prod_d[ch][t] = mul_s(win[t], wgt_q[ch][t]);
      end
    end
  end

  // Adder tree per channel: products sign-extended to ACC_W before summation.
  always_comb begin
    logic signed [ACC_W-1:0] sum;
    conv_d = '0;
    for (int ch = 0; ch < N_OC; ch++) begin
      sum = '0;
      for (int t = 0; t < TAPS; t++) begin
        sum = sum + {{(ACC_W-PROD_W){prod_q[ch][t][PROD_W-1]}}, prod_q[ch][t]};
      end
`ifdef CONV_RELU_EN
      conv_d[ch*ACC_W +: ACC_W] = sum[ACC_W-1] ? '0 : sum;
`else
      conv_d[ch*ACC_W +: ACC_W] = sum;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      prod_q <= prod_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      s1_valid_q   <= 1'b0;
      conv_valid_q <= 1'b0;
      conv_q       <= '0;
      for (int ch = 0; ch < N_OC; ch++) begin
        for (int t = 0; t < TAPS; t++) begin
          wgt_q[ch][t] <= '0;
        end
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      if (flush) begin
        s1_valid_q   <= 1'b0;
        conv_valid_q <= 1'b0;
      end else if (adv) begin
        s1_valid_q   <= win_valid_q;
        conv_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          conv_q <= conv_d;
        end
      end
      if (weight_we) begin
        for (int ch = 0; ch < N_OC; ch++) begin
          if (weight_ch == CH_W'(ch)) begin
            for (int t = 0; t < TAPS; t++) begin
              wgt_q[ch][t] <= weight_i[t*DATA_W +: DATA_W];
            end
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_data_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_conv_data_param -- scoreboard bench for conv_data_param (K=3, 5x5, 2 channels)
// Rev 1.0
// ============================================================================
module tb_conv_data_param;
  localparam int DW = 8;
  localparam int AW = 32;
  localparam int KK = 3;
  localparam int W  = 5;
  localparam int H  = 5;
  localparam int NOC = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  flush = 1'b0;
  logic [DW-1:0]         pixel_i = '0;
  logic                  pixel_valid = 1'b0;
  logic                  pixel_ready;
  logic                  weight_we = 1'b0;
  logic [0:0]            weight_ch = '0;
  logic [KK*KK*DW-1:0]   weight_i = '0;
  logic [NOC*AW-1:0]     conv_o;
  logic                  conv_valid;
  logic                  conv_ready = 1'b1;
  logic                  frame_done;

  conv_data_param #(
    .DATA_W(DW), .ACC_W(AW), .K(KK), .IMG_W(W), .IMG_H(H), .N_OC(NOC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .pixel_i(pixel_i), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .weight_we(weight_we), .weight_ch(weight_ch), .weight_i(weight_i),
    .conv_o(conv_o), .conv_valid(conv_valid), .conv_ready(conv_ready),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;
  logic [63:0] exp_q[$];
  int fd_cnt = 0;
  int stall_cnt = 0;
  int first_v = -1;
  int last_acc = 0;
  int acc13 = 0;
  logic stall_prev = 1'b0;
  logic [63:0] held = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] pk(input int ch0, input int ch1);
    return {32'(ch1), 32'(ch0)};
  endfunction

  function automatic logic [KK*KK*DW-1:0] w_all(input logic [DW-1:0] v);
    logic [KK*KK*DW-1:0] w;
    for (int t = 0; t < KK*KK; t++) w[t*DW +: DW] = v;
    return w;
  endfunction

  function automatic logic [KK*KK*DW-1:0] w_centre();
    logic [KK*KK*DW-1:0] w;
    w = '0;
    w[4*DW +: DW] = 8'd1;
    return w;
  endfunction

  // Monitor: pops the scoreboard on every handshake and checks stall behaviour.
  always @(negedge clk) begin
    logic [63:0] e;
    if (frame_done) fd_cnt++;
    if (conv_valid && first_v < 0) first_v = cyc;
    if (stall_prev && conv_valid) check("stall_hold", conv_o, held);
    if (conv_valid && !conv_ready) begin
      stall_cnt++;
      check("stall_ready_low", 64'(pixel_ready), 64'd0);
    end
    stall_prev = conv_valid && !conv_ready;
    held = conv_o;
    if (conv_valid && conv_ready) begin
      if (exp_q.size() == 0) check("unexpected_output", conv_o, 64'hDEAD);
      else begin
        e = exp_q.pop_front();
        check("result", conv_o, e);
      end
    end
  end

  task automatic load(input logic ch, input logic [KK*KK*DW-1:0] w);
    weight_we = 1'b1;
    weight_ch = ch;
    weight_i  = w;
    @(posedge clk); #1;
    weight_we = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] v);
    int n = 0;
    pixel_i = v;
    pixel_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (pixel_ready) break;
      n++;
      if (n > 100) begin
        check("pixel_accept_timeout", 64'd1, 64'd0);
        break;
      end
    end
    last_acc = cyc + 1;
    @(posedge clk); #1;
    pixel_valid = 1'b0;
  endtask

  task automatic stream(input int n, input int cval);
    for (int i = 0; i < n; i++) begin
      send((cval != 0) ? DW'(cval) : DW'(i + 1));
      if (i == 12) acc13 = last_acc;
    end
  endtask

  task automatic push_frame(input int m1);
    int v;
    for (int r = 1; r <= 3; r++)
      for (int c = 1; c <= 3; c++) begin
        v = r * W + c + 1;
        exp_q.push_back(pk(9 * v, m1 * v));
      end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int fd0;
    int st0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_conv_valid", 64'(conv_valid), 64'd0);
    check("reset_conv_o", conv_o, 64'd0);
    check("reset_frame_done", 64'(frame_done), 64'd0);
    check("reset_pixel_ready", 64'(pixel_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    load(1'b0, w_all(8'd1));
    load(1'b1, w_centre());

    // Plain frame and latency
    push_frame(1);
    fd0 = fd_cnt;
    first_v = -1;
    stream(25, 0);
    drain();
    check("latency", 64'(first_v), 64'(acc13 + 2));
    check("frame_done_s1", 64'(fd_cnt - fd0), 64'd1);

    // Backpressure mid-frame
    push_frame(1);
    fd0 = fd_cnt;
    st0 = stall_cnt;
    fork
      stream(25, 0);
      begin
        repeat (17) @(posedge clk);
        #1 conv_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 conv_ready = 1'b1;
      end
    join
    drain();
    check("stall_cycles", 64'(stall_cnt - st0), 64'd4);
    check("frame_done_s2", 64'(fd_cnt - fd0), 64'd1);

    // Negative sums
    load(1'b0, w_all(8'hFF));
`ifdef CONV_RELU_EN
    for (int i = 0; i < 9; i++) exp_q.push_back(pk(0, 127));
`else
    for (int i = 0; i < 9; i++) exp_q.push_back(pk(-1143, 127));
`endif
    stream(25, 127);
    drain();

    // Flush mid-frame, then full restream
    load(1'b0, w_all(8'd1));
    push_frame(1);
    fd0 = fd_cnt;
    stream(12, 0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    stream(25, 0);
    drain();
    check("frame_done_s4", 64'(fd_cnt - fd0), 64'd1);

    // Weight rewrite between frames
    load(1'b1, w_all(8'd2));
    push_frame(18);
    stream(25, 0);
    drain();

    // Async reset while a result is held
    load(1'b1, w_centre());
    conv_ready = 1'b0;
    stream(13, 0);
    repeat (4) @(posedge clk);
    #1;
    check("pre_reset_valid", 64'(conv_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", 64'(conv_valid), 64'd0);
    check("async_reset_conv_o", conv_o, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    conv_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) exp_q.push_back(pk(0, 0));
    stream(25, 0);
    drain();
    load(1'b0, w_all(8'd1));
    load(1'b1, w_centre());
    push_frame(1);
    fd0 = fd_cnt;
    stream(25, 0);
    drain();
    check("frame_done_s6", 64'(fd_cnt - fd0), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_data_param.md
Name: conv_data_param

Overview:
- Parametrised, self-contained streaming datapath for a convolution layer.
- Owns a (K-1)-row line buffer, a KxK sliding window, per-channel weight banks and N_OC parallel multiply/adder-tree lanes.
- Sits between the pixel source and the result writer; it is the generalised successor of the fixed 8-bit first-layer datapath.
- Adds arbitrary image size, kernel size and channel count, ready/valid backpressure, frame tracking and signed arithmetic.

Parameters:
DATA_W, 8, signed pixel/weight width
ACC_W, 32, signed result width per channel; must be >= 2*DATA_W+clog2(K*K)
K, 3, kernel edge length (K>=2)
IMG_W, 28, image width in pixels
IMG_H, 28, image height in pixels
N_OC, 4, output channels computed in parallel

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous frame restart
pixel_i  input  DATA_W  signed pixel, raster order
pixel_valid  input  1  pixel_i valid
pixel_ready  output  1  pixel accepted when valid&ready
weight_we  input  1  weight bank write strobe
weight_ch  input  clog2(N_OC)  channel selected for write
weight_i  input  K*K*DATA_W  kernel, tap 0 (top-left) in LSBs, row-major
conv_o  output  N_OC*ACC_W  results, channel 0 in LSBs
conv_valid  output  1  conv_o valid
conv_ready  input  1  downstream accepts conv_o
frame_done  output  1  one-cycle pulse on acceptance of last pixel of frame

Behaviour:
- Reset (async, rst_n=0): conv_o=0, conv_valid=0, frame_done=0, row/col counters=0, all pipeline valids=0, weight banks=0. Line buffer contents are don't-care; they are never read before being refilled.
- Advance: adv = !conv_valid | conv_ready. pixel_ready = adv. Every pipeline stage updates only when adv=1. A stall holds conv_o stable.
- Accept (pixel_valid&pixel_ready):
  - pixel shifts into window and line buffer; col increments.
  - col wraps IMG_W-1 -> 0 with row+1.
  - at row=IMG_H-1, col=IMG_W-1: row wraps to 0 and frame_done pulses in the next cycle.
- Window valid flag is set for an accept at row>=K-1 && col>=K-1, otherwise cleared. When adv=1 and no accept occurs, a bubble (valid=0) advances.
- Pipeline:
  - Stage 1 registers N_OC*K*K signed products (2*DATA_W each).
  - Stage 2 registers the sign-extended sum per channel into conv_o.
  - Latency: accept edge N -> conv_valid high after edge N+2, given no stall.
  - Throughput: 1 result/cycle.
- Outputs per frame: exactly (IMG_W-K+1)*(IMG_H-K+1).
- Weights: on weight_we, bank[weight_ch] <= weight_i. The new value is used by any stage-1 multiply at later edges. A write coincident with a multiply edge uses the old value. Weights survive flush.
- flush:
  - clears row/col counters, window valid, stage valids, conv_valid and frame_done.
  - has priority over a same-cycle accept; the pixel is dropped and pixel_ready is still driven by adv.
- Arithmetic: two's complement throughout. No saturation; the ACC_W sizing rule guarantees no overflow.
- Reset mid-frame: same as the reset state. The next accepted pixel is treated as (row 0, col 0).

Optional Feature:
CONV_RELU_EN
- Defined: each channel of stage 2 outputs max(sum,0); negative sums become 0. Latency is unchanged.
- Undefined: raw signed sums are output.

Test Plan:
- Config K=3, IMG_W=IMG_H=5, N_OC=2. ch0 weights all 1, ch1 centre tap 1, others 0. Stream pixels 1..25 back-to-back, conv_ready=1.
  -> 9 results. First is ch0=63, ch1=7; last is ch0=171, ch1=19. conv_valid first rises 2 cycles after accepting pixel 13. frame_done pulses once after pixel 25.
- Same stream with conv_ready low for 4 cycles mid-frame.
  -> pixel_ready=0 while conv_valid=1 and stalled; conv_o held. The full sequence of 9 results is identical to the unstalled run.
- ch0 weights all -1, all pixels 127, without CONV_RELU_EN.
  -> ch0=-1143 (sign-extended to ACC_W). With CONV_RELU_EN -> 0.
- flush asserted after 12 pixels, then the full frame 1..25 is restreamed.
  -> no output from the aborted part; exactly 9 results matching scenario 1.
- Rewrite ch1 weights to all 2 between frames.
  -> the next frame's first result is ch1=126 while ch0=63 is unchanged.
- Assert rst_n low mid-frame while conv_valid=1.
  -> conv_valid=0 and conv_o=0 immediately. The weights must be reloaded, and the restarted frame reproduces scenario 1.
